// File: rtl/regfile_scoreboard_if.sv
// Issue/read/writeback bundle between the issue stage and the register file scoreboard.
// The master drives addresses, issue and writeback; the slave returns read data, stall and status.
interface regfile_scoreboard_if #(
  parameter int XLEN = 16,
  parameter int NREG = 8,
  parameter int AW   = 3
);
  logic [AW-1:0]   rs1_addr_i;
  logic [AW-1:0]   rs2_addr_i;
  logic            rs1_used_i;
  logic            rs2_used_i;
  logic [XLEN-1:0] rs1_data_o;
  logic [XLEN-1:0] rs2_data_o;
  logic            issue_valid_i;
  logic            issue_wr_i;
  logic [AW-1:0]   issue_rd_i;
  logic            wb_valid_i;
  logic [AW-1:0]   wb_rd_i;
  logic [XLEN-1:0] wb_data_i;
  logic            flush_i;
  logic            stall_o;
  logic [NREG-1:0] busy_o;
  logic            underflow_o;

  modport master (
    output rs1_addr_i, rs2_addr_i, rs1_used_i, rs2_used_i,
    output issue_valid_i, issue_wr_i, issue_rd_i,
    output wb_valid_i, wb_rd_i, wb_data_i, flush_i,
    input  rs1_data_o, rs2_data_o, stall_o, busy_o, underflow_o
  );

  modport slave (
    input  rs1_addr_i, rs2_addr_i, rs1_used_i, rs2_used_i,
    input  issue_valid_i, issue_wr_i, issue_rd_i,
    input  wb_valid_i, wb_rd_i, wb_data_i, flush_i,
    output rs1_data_o, rs2_data_o, stall_o, busy_o, underflow_o
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Architectural register file with same-cycle writeback bypass and per-register pending-write
// counters; reads and stall are combinational, state updates on the rising clock edge.
module regfile_scoreboard #(
  parameter int XLEN = 16,
  parameter int NREG = 8,
  parameter int AW   = 3,
  parameter int CNTW = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  regfile_scoreboard_if.slave sb
);

  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  logic [XLEN-1:0] r_regs [NREG];
  logic [CNTW-1:0] r_cnt  [NREG];
  logic            r_underflow;

  logic [NREG-1:0] w_inc;
  logic [NREG-1:0] w_dec;
  logic [NREG-1:0] w_busy;
  logic            w_haz1;
  logic            w_haz2;
  logic            w_hazw;
  logic            w_stall;
  logic            w_fire;
  logic [XLEN-1:0] w_rs1;
  logic [XLEN-1:0] w_rs2;

  always_comb begin
    w_dec  = '0;
    w_busy = '0;
    for (int r = 1; r < NREG; r++) begin
      w_dec[r]  = sb.wb_valid_i && (sb.wb_rd_i == AW'(r));
      w_busy[r] = (r_cnt[r] != '0);
    end
  end

  // A single outstanding write that retires this cycle is served by the bypass, so no stall.
  always_comb begin
    w_haz1 = sb.rs1_used_i && (sb.rs1_addr_i != '0) &&
             ((r_cnt[sb.rs1_addr_i] > CNTW'(1)) ||
              ((r_cnt[sb.rs1_addr_i] == CNTW'(1)) && !w_dec[sb.rs1_addr_i]));
    w_haz2 = sb.rs2_used_i && (sb.rs2_addr_i != '0) &&
             ((r_cnt[sb.rs2_addr_i] > CNTW'(1)) ||
              ((r_cnt[sb.rs2_addr_i] == CNTW'(1)) && !w_dec[sb.rs2_addr_i]));
    w_hazw = sb.issue_wr_i && (sb.issue_rd_i != '0) &&
             (r_cnt[sb.issue_rd_i] == CNT_MAX) && !w_dec[sb.issue_rd_i];
    w_stall = sb.issue_valid_i && (w_haz1 || w_haz2 || w_hazw);
    w_fire  = sb.issue_valid_i && !w_stall;
  end

  always_comb begin
    w_inc = '0;
    for (int r = 1; r < NREG; r++) begin
      w_inc[r] = w_fire && sb.issue_wr_i && (sb.issue_rd_i == AW'(r));
    end
  end

  always_comb begin
    w_rs1 = r_regs[sb.rs1_addr_i];
    if (sb.rs1_addr_i == '0) begin
      w_rs1 = '0;
    end else if (sb.wb_valid_i && (sb.wb_rd_i == sb.rs1_addr_i)) begin
      w_rs1 = sb.wb_data_i;
    end
    w_rs2 = r_regs[sb.rs2_addr_i];
    if (sb.rs2_addr_i == '0) begin
      w_rs2 = '0;
    end else if (sb.wb_valid_i && (sb.wb_rd_i == sb.rs2_addr_i)) begin
      w_rs2 = sb.wb_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NREG; r++) begin
        r_regs[r] <= '0;
        r_cnt[r]  <= '0;
      end
      r_underflow <= 1'b0;
    end else begin
      if (sb.wb_valid_i && (sb.wb_rd_i != '0)) begin
        r_regs[sb.wb_rd_i] <= sb.wb_data_i;
      end
      for (int r = 1; r < NREG; r++) begin
        if (w_dec[r] && !w_inc[r] && (r_cnt[r] == '0)) begin
          r_underflow <= 1'b1;
        end
        if (sb.flush_i) begin
          r_cnt[r] <= '0;
        end else if (w_inc[r] && !w_dec[r]) begin
          r_cnt[r] <= r_cnt[r] + CNTW'(1);
        end else if (w_dec[r] && !w_inc[r] && (r_cnt[r] != '0)) begin
          r_cnt[r] <= r_cnt[r] - CNTW'(1);
        end
      end
    end
  end

  assign sb.rs1_data_o  = w_rs1;
  assign sb.rs2_data_o  = w_rs2;
  assign sb.stall_o     = w_stall;
  assign sb.busy_o      = w_busy;
  assign sb.underflow_o = r_underflow;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: bypass, RAW and full-counter stalls, underflow,
// x0 handling, flush and mid-operation reset, each checked against hand-computed values.
module tb_regfile_scoreboard;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  regfile_scoreboard_if #(.XLEN(16), .NREG(8), .AW(3)) sb ();

  regfile_scoreboard #(.XLEN(16), .NREG(8), .AW(3), .CNTW(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .sb    (sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sb.rs1_used_i    = 1'b0;
    sb.rs2_used_i    = 1'b0;
    sb.issue_valid_i = 1'b0;
    sb.issue_wr_i    = 1'b0;
    sb.issue_rd_i    = '0;
    sb.wb_valid_i    = 1'b0;
    sb.wb_rd_i       = '0;
    sb.wb_data_i     = '0;
    sb.flush_i       = 1'b0;
  endtask

  task automatic issue_wr(input logic [2:0] rd);
    sb.issue_valid_i = 1'b1;
    sb.issue_wr_i    = 1'b1;
    sb.issue_rd_i    = rd;
    step();
    idle();
  endtask

  task automatic wb(input logic [2:0] rd, input logic [15:0] d);
    sb.wb_valid_i = 1'b1;
    sb.wb_rd_i    = rd;
    sb.wb_data_i  = d;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle();
    sb.rs1_addr_i = '0;
    sb.rs2_addr_i = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;

    // reset state
    for (int a = 1; a < 8; a++) begin
      sb.rs1_addr_i = 3'(a);
      sb.rs2_addr_i = 3'(a);
      #1;
      chk("rst_rs1", 32'(sb.rs1_data_o), 32'h0);
      chk("rst_rs2", 32'(sb.rs2_data_o), 32'h0);
    end
    chk("rst_busy", 32'(sb.busy_o), 32'h0);
    chk("rst_uf", 32'(sb.underflow_o), 32'h0);
    chk("rst_stall", 32'(sb.stall_o), 32'h0);

    // bypass on x3, then registered value
    issue_wr(3'd3);
    chk("x3_busy", 32'(sb.busy_o), 32'h08);
    sb.rs1_addr_i = 3'd3;
    wb(3'd3, 16'hBEEF);
    #1;
    chk("x3_bypass", 32'(sb.rs1_data_o), 32'hBEEF);
    step();
    idle();
    #1;
    chk("x3_reg", 32'(sb.rs1_data_o), 32'hBEEF);
    chk("x3_busy_clr", 32'(sb.busy_o), 32'h0);
    chk("x3_uf", 32'(sb.underflow_o), 32'h0);

    // RAW on x5 resolved by same-cycle writeback
    issue_wr(3'd5);
    sb.issue_valid_i = 1'b1;
    sb.rs1_used_i    = 1'b1;
    sb.rs1_addr_i    = 3'd5;
    #1;
    chk("raw_stall", 32'(sb.stall_o), 32'h1);
    wb(3'd5, 16'h1234);
    #1;
    chk("raw_bypass_stall", 32'(sb.stall_o), 32'h0);
    chk("raw_bypass_data", 32'(sb.rs1_data_o), 32'h1234);
    step();
    idle();
    #1;
    chk("x5_busy_clr", 32'(sb.busy_o), 32'h0);

    // x2 fills to max
    issue_wr(3'd2);
    issue_wr(3'd2);
    issue_wr(3'd2);
    chk("x2_busy", 32'(sb.busy_o), 32'h04);
    sb.issue_valid_i = 1'b1;
    sb.rs2_used_i    = 1'b1;
    sb.rs2_addr_i    = 3'd2;
    wb(3'd2, 16'h5555);
    #1;
    chk("raw_cnt3_stall", 32'(sb.stall_o), 32'h1);
    chk("raw_cnt3_rs2", 32'(sb.rs2_data_o), 32'h5555);
    idle();
    sb.issue_valid_i = 1'b1;
    sb.issue_wr_i    = 1'b1;
    sb.issue_rd_i    = 3'd2;
    #1;
    chk("full_stall", 32'(sb.stall_o), 32'h1);
    wb(3'd2, 16'h0002);
    #1;
    chk("full_wb_stall", 32'(sb.stall_o), 32'h0);
    step();
    idle();
    // inc and dec together held the count at 3; drain it
    sb.issue_valid_i = 1'b1;
    sb.issue_wr_i    = 1'b1;
    sb.issue_rd_i    = 3'd2;
    #1;
    chk("full_hold_stall", 32'(sb.stall_o), 32'h1);
    idle();
    for (int i = 0; i < 3; i++) begin
      wb(3'd2, 16'(16'h0A00 + i));
      step();
    end
    idle();
    #1;
    chk("x2_drained", 32'(sb.busy_o), 32'h0);
    chk("x2_no_uf", 32'(sb.underflow_o), 32'h0);
    sb.rs2_addr_i = 3'd2;
    #1;
    chk("x2_last", 32'(sb.rs2_data_o), 32'h0A02);

    // underflow on x4 is sticky
    wb(3'd4, 16'h0044);
    step();
    idle();
    chk("uf_set", 32'(sb.underflow_o), 32'h1);
    step();
    chk("uf_sticky", 32'(sb.underflow_o), 32'h1);

    // x0 ignores writes and issue
    sb.rs1_addr_i = 3'd0;
    wb(3'd0, 16'hFFFF);
    #1;
    chk("x0_bypass", 32'(sb.rs1_data_o), 32'h0);
    step();
    idle();
    #1;
    chk("x0_reg", 32'(sb.rs1_data_o), 32'h0);
    issue_wr(3'd0);
    chk("x0_busy", 32'(sb.busy_o), 32'h0);

    // flush with concurrent writeback
    issue_wr(3'd1);
    issue_wr(3'd1);
    issue_wr(3'd6);
    chk("pre_flush_busy", 32'(sb.busy_o), 32'h42);
    sb.issue_valid_i = 1'b1;
    sb.rs1_used_i    = 1'b1;
    sb.rs1_addr_i    = 3'd1;
    sb.flush_i       = 1'b1;
    #1;
    chk("flush_stall", 32'(sb.stall_o), 32'h1);
    idle();
    sb.flush_i = 1'b1;
    wb(3'd6, 16'h00AA);
    step();
    idle();
    sb.rs1_addr_i = 3'd6;
    #1;
    chk("flush_busy", 32'(sb.busy_o), 32'h0);
    chk("flush_reg6", 32'(sb.rs1_data_o), 32'h00AA);
    chk("flush_uf", 32'(sb.underflow_o), 32'h1);

    // reset mid-operation wins over issue and writeback
    issue_wr(3'd3);
    rst              = 1'b1;
    sb.issue_valid_i = 1'b1;
    sb.issue_wr_i    = 1'b1;
    sb.issue_rd_i    = 3'd7;
    wb(3'd7, 16'h7777);
    step();
    rst = 1'b0;
    idle();
    sb.rs1_addr_i = 3'd3;
    sb.rs2_addr_i = 3'd7;
    #1;
    chk("rst2_busy", 32'(sb.busy_o), 32'h0);
    chk("rst2_uf", 32'(sb.underflow_o), 32'h0);
    chk("rst2_x3", 32'(sb.rs1_data_o), 32'h0);
    chk("rst2_x7", 32'(sb.rs2_data_o), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
